// File: rtl/decoder_pkg.sv
// decoder_pkg: opcode constants, alu_op encodings and control bundle for the decode stage
package decoder_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_LD = 4'h3;
  localparam logic [3:0] OP_ST = 4'h4;
  localparam logic [3:0] OP_MUL = 4'h5;
  localparam logic [3:0] OP_DIV = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_CONST = 4'h8;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_BRNZP = 4'hA;
  localparam logic [3:0] OP_RET = 4'hB;
  localparam logic [3:0] OP_ILLEGAL = 4'hC;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    alu_op_t alu_op;
    logic alu_src_imm;
    logic nzp_write;
    logic branch;
    logic ret;
    logic illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_NOP: ;
      OP_ADD: c.reg_write = 1'b1;
      OP_SUB: begin c.reg_write = 1'b1; c.alu_op = ALU_SUB; end
      OP_LD: begin c.reg_write = 1'b1; c.mem_read = 1'b1; end
      OP_ST: c.mem_write = 1'b1;
      OP_MUL: begin c.reg_write = 1'b1; c.alu_op = ALU_MUL; end
      OP_DIV: begin c.reg_write = 1'b1; c.alu_op = ALU_DIV; end
      OP_ADDI, OP_CONST: begin c.reg_write = 1'b1; c.alu_src_imm = 1'b1; end
      OP_CMP: begin c.nzp_write = 1'b1; c.alu_op = ALU_SUB; end
      OP_BRNZP: c.branch = 1'b1;
      OP_RET: c.ret = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/decode_logic.sv
// decode_logic: combinational split of an instruction word into fields and controls
module decode_logic
  import decoder_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int OPCODE_WIDTH = 4,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int IMM_WIDTH = INST_WIDTH - OPCODE_WIDTH - 3 * REG_ADDR_WIDTH
) (
  input  logic [INST_WIDTH-1:0]     instruction,
  output logic [OPCODE_WIDTH-1:0]   opcode,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [REG_ADDR_WIDTH-1:0] rs,
  output logic [REG_ADDR_WIDTH-1:0] rt,
  output logic [IMM_WIDTH-1:0]      immediate,
  output ctrl_t                     ctrl
);
  localparam int RD_TOP = INST_WIDTH - OPCODE_WIDTH - 1;
  logic [OPCODE_WIDTH+3:0] op_ext;
  logic op_high;
  assign opcode = instruction[INST_WIDTH-1 -: OPCODE_WIDTH];
  assign rd = instruction[RD_TOP -: REG_ADDR_WIDTH];
  assign rs = instruction[RD_TOP - REG_ADDR_WIDTH -: REG_ADDR_WIDTH];
  assign rt = instruction[RD_TOP - 2 * REG_ADDR_WIDTH -: REG_ADDR_WIDTH];
  assign immediate = instruction[IMM_WIDTH-1:0];
  assign op_ext = {4'b0, opcode};
  assign op_high = op_ext >= (OPCODE_WIDTH + 4)'(12);
  assign ctrl = decode_ctrl(op_high ? OP_ILLEGAL : op_ext[3:0]);
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered valid/ready decode stage with RET halt and illegal-opcode counter
module decode_stage
  import decoder_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int OPCODE_WIDTH = 4,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int COUNT_WIDTH = 8,
  localparam int IMM_WIDTH = INST_WIDTH - OPCODE_WIDTH - 3 * REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INST_WIDTH-1:0]     instruction,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPCODE_WIDTH-1:0]   opcode,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [REG_ADDR_WIDTH-1:0] rs,
  output logic [REG_ADDR_WIDTH-1:0] rt,
  output logic [IMM_WIDTH-1:0]      immediate,
  output logic                      reg_write_enable,
  output logic                      mem_read_enable,
  output logic                      mem_write_enable,
  output logic [1:0]                alu_op,
  output logic                      alu_src_imm,
  output logic                      nzp_write,
  output logic                      branch,
  output logic                      ret,
  output logic                      illegal,
  output logic                      halted,
  output logic [COUNT_WIDTH-1:0]    illegal_count
);
  if (IMM_WIDTH < 1) begin : g_bad_imm
    $error("decode_stage: immediate field width must be at least 1");
  end

  typedef enum logic {RUN, HALTED} state_t;
  state_t state_q, state_d;
  logic [OPCODE_WIDTH-1:0] dec_opcode;
  logic [REG_ADDR_WIDTH-1:0] dec_rd, dec_rs, dec_rt;
  logic [IMM_WIDTH-1:0] dec_imm;
  ctrl_t dec_ctrl, ctrl_q;
  logic accept;

  decode_logic #(
    .INST_WIDTH(INST_WIDTH),
    .OPCODE_WIDTH(OPCODE_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .IMM_WIDTH(IMM_WIDTH)
  ) u_decode (
    .instruction(instruction),
    .opcode(dec_opcode),
    .rd(dec_rd),
    .rs(dec_rs),
    .rt(dec_rt),
    .immediate(dec_imm),
    .ctrl(dec_ctrl)
  );

  assign halted = state_q == HALTED;
  assign in_ready = !halted && !flush && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;

  // halt after an accepted RET; only flush (or reset) resumes intake
  always_comb begin
    state_d = state_q;
    if (flush) state_d = RUN;
    else if (accept && dec_ctrl.ret) state_d = HALTED;
  end

  // state register
  always_ff @(posedge clk) state_q <= reset ? RUN : state_d;

  // output bundle register: load on accept, drop on drain or flush, hold while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      ctrl_q <= '0;
      opcode <= '0;
      rd <= '0;
      rs <= '0;
      rt <= '0;
      immediate <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl_q <= dec_ctrl;
      opcode <= dec_opcode;
      rd <= dec_rd;
      rs <= dec_rs;
      rt <= dec_rt;
      immediate <= dec_imm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // saturating count of accepted illegal instructions; survives flush
  always_ff @(posedge clk) begin
    if (reset) illegal_count <= '0;
    else if (accept && dec_ctrl.illegal && illegal_count != '1) illegal_count <= illegal_count + 1'b1;
  end

  assign reg_write_enable = ctrl_q.reg_write;
  assign mem_read_enable = ctrl_q.mem_read;
  assign mem_write_enable = ctrl_q.mem_write;
  assign alu_op = ctrl_q.alu_op;
  assign alu_src_imm = ctrl_q.alu_src_imm;
  assign nzp_write = ctrl_q.nzp_write;
  assign branch = ctrl_q.branch;
  assign ret = ctrl_q.ret;
  assign illegal = ctrl_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage
module tb_decode_stage;
  typedef logic [41:0] bund_t;
  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [31:0] instruction;
  logic in_ready, out_valid;
  logic [3:0] opcode, rd, rs, rt;
  logic [15:0] immediate;
  logic reg_write_enable, mem_read_enable, mem_write_enable;
  logic [1:0] alu_op;
  logic alu_src_imm, nzp_write, branch, ret, illegal, halted;
  logic [7:0] illegal_count;
  bund_t dut_bundle;
  bund_t q[$];
  logic m_valid, m_halted, exp_ready;
  logic [7:0] m_count;
  int passed = 0;
  int total = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .immediate(immediate),
    .reg_write_enable(reg_write_enable), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .nzp_write(nzp_write), .branch(branch), .ret(ret), .illegal(illegal),
    .halted(halted), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  assign dut_bundle = {opcode, rd, rs, rt, immediate, reg_write_enable, mem_read_enable,
                       mem_write_enable, alu_op, alu_src_imm, nzp_write, branch, ret, illegal};

  function automatic bund_t exp_bundle(input logic [31:0] w);
    logic rw, mr, mw, src, nzp, br, rt_f, ill;
    logic [1:0] alu;
    {rw, mr, mw, src, nzp, br, rt_f, ill} = '0;
    alu = 2'b00;
    case (w[31:28])
      4'h0: ;
      4'h1: rw = 1'b1;
      4'h2: begin rw = 1'b1; alu = 2'b01; end
      4'h3: begin rw = 1'b1; mr = 1'b1; end
      4'h4: mw = 1'b1;
      4'h5: begin rw = 1'b1; alu = 2'b10; end
      4'h6: begin rw = 1'b1; alu = 2'b11; end
      4'h7, 4'h8: begin rw = 1'b1; src = 1'b1; end
      4'h9: begin nzp = 1'b1; alu = 2'b01; end
      4'hA: br = 1'b1;
      4'hB: rt_f = 1'b1;
      default: ill = 1'b1;
    endcase
    return {w, rw, mr, mw, alu, src, nzp, br, rt_f, ill};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    exp_ready = !m_halted && !flush && (!m_valid || out_ready);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("halted", 64'(halted), 64'(m_halted));
    chk("illegal_count", 64'(illegal_count), 64'(m_count));
    if (m_valid) begin
      if (q.size() == 0) chk("scoreboard_empty", 64'(dut_bundle), 64'(1) << 63);
      else chk("bundle", 64'(dut_bundle), 64'(q[0]));
    end
    if (reset) begin
      m_valid = 1'b0; m_halted = 1'b0; m_count = '0; q.delete();
    end else if (flush) begin
      m_valid = 1'b0; m_halted = 1'b0; q.delete();
    end else begin
      if (m_valid && out_ready) begin
        void'(q.pop_front());
        m_valid = 1'b0;
      end
      if (in_valid && exp_ready) begin
        q.push_back(exp_bundle(instruction));
        m_valid = 1'b1;
        if (instruction[31:28] == 4'hB) m_halted = 1'b1;
        if (instruction[31:28] >= 4'hC && m_count != 8'hFF) m_count++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w);
    in_valid = v;
    instruction = w;
    tick();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instruction = '0;
    m_valid = 1'b0; m_halted = 1'b0; m_count = '0;
    @(posedge clk); #1;
    tick();
    reset = 1'b0;
    chk("reset_bundle", 64'(dut_bundle), 64'(0));
    drive(1'b1, 32'h1123_0000);
    drive(1'b1, 32'h3400_00FF);
    drive(1'b1, 32'h4560_0000);
    drive(1'b1, 32'h7120_0010);
    drive(1'b1, 32'h8AB0_1234);
    drive(1'b1, 32'h9120_0000);
    drive(1'b1, 32'h6789_0000);
    drive(1'b1, 32'hA000_0042);
    drive(1'b1, 32'h0000_0000);
    drive(1'b0, 32'h0);
    out_ready = 1'b0;
    drive(1'b1, 32'h2123_0000);
    drive(1'b1, 32'h1456_0000);
    drive(1'b1, 32'h1456_0000);
    drive(1'b1, 32'h1456_0000);
    out_ready = 1'b1;
    drive(1'b1, 32'h1456_0000);
    drive(1'b0, 32'h0);
    for (int i = 0; i < 300; i++) drive(1'b1, {4'hC + 4'(i % 4), 28'($urandom)});
    drive(1'b0, 32'h0);
    chk("count_saturated", 64'(illegal_count), 64'(255));
    drive(1'b1, 32'hB000_0000);
    drive(1'b1, 32'h1123_0000);
    drive(1'b1, 32'h1123_0000);
    flush = 1'b1;
    drive(1'b1, 32'h1123_0000);
    flush = 1'b0;
    drive(1'b1, 32'h1123_0000);
    drive(1'b0, 32'h0);
    flush = 1'b1;
    drive(1'b1, 32'h5123_0000);
    flush = 1'b0;
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    out_ready = 1'b0;
    drive(1'b1, 32'h1FFF_FFFF);
    drive(1'b0, 32'h0);
    reset = 1'b1;
    drive(1'b0, 32'h0);
    reset = 1'b0;
    chk("reset_stall_bundle", 64'(dut_bundle), 64'(0));
    chk("reset_stall_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    drive(1'b1, 32'hE000_0000);
    drive(1'b0, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
